// File: rtl/wm8731_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wm8731_pkg : codec address, register map and configuration table     |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
package wm8731_pkg;

  localparam logic [7:0] WM8731_I2C_ADDR = 8'h34;

  localparam logic [6:0] REG_LLINE  = 7'h00;
  localparam logic [6:0] REG_RLINE  = 7'h01;
  localparam logic [6:0] REG_LHP    = 7'h02;
  localparam logic [6:0] REG_RHP    = 7'h03;
  localparam logic [6:0] REG_APATH  = 7'h04;
  localparam logic [6:0] REG_DPATH  = 7'h05;
  localparam logic [6:0] REG_PWR    = 7'h06;
  localparam logic [6:0] REG_IFACE  = 7'h07;
  localparam logic [6:0] REG_ACTIVE = 7'h09;
  localparam logic [6:0] REG_RESET  = 7'h0F;

  localparam int CFG_LEN = 10;

  // {addr[6:0], data[8:0]}; sampling control stays at its reset default
  // (normal mode, 48 kHz), and activation must be the final write.
  localparam logic [15:0] CFG_TABLE [CFG_LEN] = '{
    {REG_RESET,  9'h000},
    {REG_LLINE,  9'h017},
    {REG_RLINE,  9'h017},
    {REG_LHP,    9'h079},
    {REG_RHP,    9'h079},
    {REG_APATH,  9'h012},
    {REG_DPATH,  9'h000},
    {REG_PWR,    9'h000},
    {REG_IFACE,  9'h002},
    {REG_ACTIVE, 9'h001}
  };

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_BIT, ST_ACK, ST_STOP, ST_GAP, ST_FINISH, ST_FAIL
  } state_t;

  typedef enum logic [2:0] {
    SEQ_IDLE, SEQ_ISSUE, SEQ_WAIT, SEQ_FINISH, SEQ_FAIL
  } seq_t;

  localparam logic [1:0] OP_START_BYTE = 2'd0;
  localparam logic [1:0] OP_BYTE       = 2'd1;
  localparam logic [1:0] OP_STOP       = 2'd2;

endpackage
`default_nettype wire

// File: rtl/wm8731_cfg_sequencer_i2c_byte_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | i2c_byte_tx : quarter-tick I2C framer (START+byte, byte, STOP+gap)   |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module i2c_byte_tx
  import wm8731_pkg::*;
#(
  parameter int QTR_DIV  = 31,
  parameter int GAP_QTRS = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       go,
  input  logic [1:0] op,
  input  logic [7:0] data,
  input  logic       sda_in,
  output logic       ready,
  output logic       nack,
  output logic       scl,
  output logic       sda_oe
);

  localparam int c_DW = (QTR_DIV > 1) ? $clog2(QTR_DIV) : 1;
  localparam logic [c_DW-1:0] c_DIV_LAST = c_DW'(QTR_DIV - 1);
  localparam int c_GW = (GAP_QTRS > 1) ? $clog2(GAP_QTRS) : 1;
  localparam logic [c_GW-1:0] c_GAP_LAST = c_GW'(GAP_QTRS - 1);

  logic [c_DW-1:0] r_div;
  logic            w_qtick;
  state_t          r_state;
  logic [1:0]      r_q;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic [c_GW-1:0] r_gap;

  assign w_qtick = enable && (r_div == c_DIV_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          r_div <= '0;
    else if (!w_qtick && enable) r_div <= r_div + 1'b1;
    else                 r_div <= '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_q     <= 2'd0;
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
      r_gap   <= '0;
      ready   <= 1'b0;
      nack    <= 1'b0;
      scl     <= 1'b1;
      sda_oe  <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (r_state)
        ST_IDLE: if (go) begin
          r_shift <= data;
          r_q     <= 2'd0;
          r_bit   <= 3'd0;
          r_gap   <= '0;
          nack    <= 1'b0;
          if (op == OP_STOP)            r_state <= ST_STOP;
          else if (op == OP_START_BYTE) r_state <= ST_START;
          else                          r_state <= ST_BIT;
        end
        ST_START: if (w_qtick) begin
          r_q <= r_q + 2'd1;
          case (r_q)
            2'd0:    begin sda_oe <= 1'b0; scl <= 1'b1; end
            2'd1:    sda_oe <= 1'b1;
            2'd2:    scl <= 1'b0;
            default: r_state <= ST_BIT;
          endcase
        end
        ST_BIT: if (w_qtick) begin
          r_q <= r_q + 2'd1;
          case (r_q)
            2'd0: sda_oe <= ~r_shift[7];
            2'd1: scl <= 1'b1;
            2'd3: begin
              scl     <= 1'b0;
              r_shift <= {r_shift[6:0], 1'b0};
              r_bit   <= r_bit + 3'd1;
              if (r_bit == 3'd7) r_state <= ST_ACK;
            end
            default: ;
          endcase
        end
        ST_ACK: if (w_qtick) begin
          r_q <= r_q + 2'd1;
          case (r_q)
            2'd0:    sda_oe <= 1'b0;
            2'd1:    scl <= 1'b1;
            2'd2:    nack <= sda_in;
            default: begin scl <= 1'b0; ready <= 1'b1; r_state <= ST_IDLE; end
          endcase
        end
        ST_STOP: if (w_qtick) begin
          r_q <= r_q + 2'd1;
          case (r_q)
            2'd0:    sda_oe <= 1'b1;
            2'd1:    scl <= 1'b1;
            2'd2:    sda_oe <= 1'b0;
            default: r_state <= ST_GAP;
          endcase
        end
        ST_GAP: if (w_qtick) begin
          if (r_gap == c_GAP_LAST) begin
            ready   <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/wm8731_cfg_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wm8731_cfg_sequencer : walks the codec table, retries NACKed entries |
// | Revision             : 1.0                                           |
// +----------------------------------------------------------------------+
module wm8731_cfg_sequencer
  import wm8731_pkg::*;
#(
  parameter int QTR_DIV   = 31,
  parameter int NUM_REGS  = 10,
  parameter int MAX_RETRY = 3,
  parameter int GAP_QTRS  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       sda_in,
  output logic       scl,
  output logic       sda_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_error,
  output logic       i2s_enable,
  output logic [3:0] cur_index
);

  localparam int c_RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [c_RW-1:0] c_MAX_RETRY = c_RW'(MAX_RETRY);
  localparam logic [3:0]      c_LAST      = 4'(NUM_REGS - 1);

  seq_t            r_seq;
  logic [1:0]      r_step;   // 0..2 = byte index, 3 = STOP plus gap
  logic [c_RW-1:0] r_retry;
  logic            r_nack;
  logic            r_go;
  logic [1:0]      r_op;
  logic [7:0]      r_data;
  logic [15:0]     w_entry;
  logic [7:0]      w_byte;
  logic [1:0]      w_op;
  logic            w_ready;
  logic            w_nack;

  assign i2s_enable = done;

  always_comb begin
    w_entry = CFG_TABLE[cur_index];
    w_byte  = WM8731_I2C_ADDR;
    w_op    = OP_BYTE;
    case (r_step)
      2'd0:    w_op   = OP_START_BYTE;
      2'd1:    w_byte = w_entry[15:8];
      2'd2:    w_byte = w_entry[7:0];
      default: w_op   = OP_STOP;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_seq     <= SEQ_IDLE;
      r_step    <= 2'd0;
      r_retry   <= '0;
      r_nack    <= 1'b0;
      r_go      <= 1'b0;
      r_op      <= OP_STOP;
      r_data    <= 8'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ack_error <= 1'b0;
      cur_index <= 4'd0;
    end else begin
      r_go <= 1'b0;
      case (r_seq)
        SEQ_IDLE: if (start) begin
          busy      <= 1'b1;
          done      <= 1'b0;
          ack_error <= 1'b0;
          cur_index <= 4'd0;
          r_retry   <= '0;
          r_step    <= 2'd0;
          r_nack    <= 1'b0;
          r_seq     <= SEQ_ISSUE;
        end
        SEQ_ISSUE: begin
          r_go   <= 1'b1;
          r_op   <= w_op;
          r_data <= w_byte;
          r_seq  <= SEQ_WAIT;
        end
        SEQ_WAIT: if (w_ready) begin
          r_seq <= SEQ_ISSUE;
          if (r_step == 2'd3) begin
            r_step <= 2'd0;
            if (r_nack) begin
              if (r_retry == c_MAX_RETRY) begin
                r_seq <= SEQ_FAIL;
              end else begin
                r_retry <= r_retry + 1'b1;
                r_nack  <= 1'b0;
              end
            end else begin
              r_retry   <= '0;
              cur_index <= cur_index + 4'd1;
              if (cur_index == c_LAST) r_seq <= SEQ_FINISH;
            end
          end else if (w_nack) begin
            r_nack <= 1'b1;
            r_step <= 2'd3;
          end else begin
            r_step <= r_step + 2'd1;
          end
        end
        SEQ_FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          r_seq <= SEQ_IDLE;
        end
        SEQ_FAIL: begin
          ack_error <= 1'b1;
          busy      <= 1'b0;
          r_seq     <= SEQ_IDLE;
        end
        default: r_seq <= SEQ_IDLE;
      endcase
    end
  end

  i2c_byte_tx #(
    .QTR_DIV  (QTR_DIV),
    .GAP_QTRS (GAP_QTRS)
  ) u_tx (
    .clk    (clk),
    .reset  (reset),
    .enable (busy),
    .go     (r_go),
    .op     (r_op),
    .data   (r_data),
    .sda_in (sda_in),
    .ready  (w_ready),
    .nack   (w_nack),
    .scl    (scl),
    .sda_oe (sda_oe)
  );

endmodule
`default_nettype wire

// File: tb/tb_wm8731_cfg_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_wm8731_cfg_sequencer : open-drain slave, frame decoder, checks    |
// | Revision                : 1.0                                        |
// +----------------------------------------------------------------------+
module tb_wm8731_cfg_sequencer;

  localparam int QTR   = 10;
  localparam int PULSE = 2 * QTR;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       sda_in;
  logic       scl, sda_oe, busy, done, ack_error, i2s_enable;
  logic [3:0] cur_index;
  logic       slave_pull = 1'b0;
  logic       mon_clear = 1'b1;

  assign sda_in = !(sda_oe || slave_pull);

  wm8731_cfg_sequencer #(
    .QTR_DIV(QTR), .NUM_REGS(10), .MAX_RETRY(3), .GAP_QTRS(8)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .sda_in(sda_in),
    .scl(scl), .sda_oe(sda_oe), .busy(busy), .done(done),
    .ack_error(ack_error), .i2s_enable(i2s_enable), .cur_index(cur_index)
  );

  always #5 clk = ~clk;

  // expected {addr,data[8]} and data[7:0] bytes of each table entry
  logic [7:0] exp_b1 [10] = '{8'h1E, 8'h00, 8'h02, 8'h04, 8'h06,
                              8'h08, 8'h0A, 8'h0C, 8'h0E, 8'h12};
  logic [7:0] exp_b2 [10] = '{8'h00, 8'h17, 8'h17, 8'h79, 8'h79,
                              8'h12, 8'h00, 8'h00, 8'h02, 8'h01};

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // slave / bus monitor state
  logic       p_scl = 1'b1, p_sda = 1'b1;
  logic       in_frame = 1'b0, skip_fall = 1'b0, first_low = 1'b0;
  int         bit_i = 0, byte_i = 0, run_len = 0;
  logic [7:0] shreg = 8'h00;
  logic [7:0] fb [3];
  logic [7:0] log_b0 [64], log_b1 [64], log_b2 [64];
  int         log_n [64];
  int         frame_count = 0;
  int         bad_proto = 0, bad_high = 0, bad_low = 0, good_high = 0;
  logic [7:0] nack_val = 8'h00;
  int         nack_limit = 0, nacks_given = 0;

  always @(negedge clk) begin
    logic sda_v;
    sda_v = !(sda_oe || slave_pull);
    if (mon_clear) begin
      in_frame = 1'b0; bit_i = 0; byte_i = 0; slave_pull = 1'b0;
      skip_fall = 1'b0; first_low = 1'b0;
    end else begin
      if (p_scl && scl && p_sda && !sda_v) begin
        if (in_frame) bad_proto++;
        in_frame = 1'b1; bit_i = 0; byte_i = 0;
        skip_fall = 1'b1; first_low = 1'b1;
        fb[0] = 8'h00; fb[1] = 8'h00; fb[2] = 8'h00;
      end else if (p_scl && scl && !p_sda && sda_v) begin
        if (!in_frame || bit_i != 0) bad_proto++;
        if (in_frame && frame_count < 64) begin
          log_b0[frame_count] = fb[0];
          log_b1[frame_count] = fb[1];
          log_b2[frame_count] = fb[2];
          log_n[frame_count]  = byte_i;
          frame_count++;
        end
        in_frame = 1'b0;
      end
      if (scl != p_scl && in_frame) begin
        if (scl) begin
          if (first_low) first_low = 1'b0;
          else if (run_len != PULSE) bad_low++;
          if (bit_i < 8) shreg = {shreg[6:0], sda_v};
          else if (byte_i < 3) fb[byte_i] = shreg;
        end else if (skip_fall) begin
          skip_fall = 1'b0;
        end else begin
          if (run_len != PULSE) bad_high++; else good_high++;
          bit_i++;
          if (bit_i == 8) begin
            if (byte_i == 1 && shreg == nack_val && nacks_given < nack_limit) begin
              nacks_given++;
              slave_pull = 1'b0;
            end else begin
              slave_pull = 1'b1;
            end
          end else if (bit_i == 9) begin
            bit_i = 0; byte_i++; slave_pull = 1'b0;
          end
        end
      end
    end
    if (scl != p_scl) run_len = 1; else run_len++;
    p_scl = scl;
    p_sda = sda_v;
  end

  typedef struct {
    int entry;
    bit nacked;
  } fvec_t;

  fvec_t vecs [30];

  function automatic int outs();
    return int'({scl, sda_oe, busy, done, ack_error, i2s_enable, cur_index});
  endfunction

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    while (busy && k < budget) begin @(negedge clk); k++; end
    check(name, int'(busy), 0);
  endtask

  task automatic wait_frames(input string name, input int n, input int budget);
    int k = 0;
    while (frame_count < n && k < budget) begin @(negedge clk); k++; end
    check(name, int'(frame_count >= n), 1);
  endtask

  initial begin
    int base;
    int k;
    for (int i = 0; i < 10; i++) vecs[i] = '{i, 1'b0};
    for (int i = 0; i < 4; i++)  vecs[10 + i] = '{i, 1'b0};
    vecs[13] = '{3, 1'b1};
    for (int i = 3; i < 10; i++) vecs[11 + i] = '{i, 1'b0};
    for (int i = 0; i < 5; i++)  vecs[21 + i] = '{i, 1'b0};
    for (int i = 0; i < 4; i++)  vecs[26 + i] = '{5, 1'b1};

    repeat (3) @(negedge clk);
    check("reset_outputs", outs(), 10'h200);
    reset = 1'b1;
    #2 mon_clear = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_outputs", outs(), 10'h200);

    // run A: clean run, second start pulse mid-run
    pulse_start();
    check("A_busy", int'(busy), 1);
    wait_frames("A_wait4", 4, 8000);
    pulse_start();
    @(negedge clk);
    check("A_restart_ignored_idx", int'(cur_index), 3);
    wait_idle("A_idle", 20000);
    check("A_frames", frame_count, 10);
    check("A_done", int'(done), 1);
    check("A_i2s", int'(i2s_enable), 1);
    check("A_ack_error", int'(ack_error), 0);
    check("A_cur_index", int'(cur_index), 10);

    // run B: rerun after done, entry 3 NACKed once on byte1
    nack_val = 8'h04;
    nack_limit = nacks_given + 1;
    pulse_start();
    check("B_done_drop", int'(done), 0);
    check("B_i2s_drop", int'(i2s_enable), 0);
    wait_idle("B_idle", 22000);
    check("B_frames", frame_count, 21);
    check("B_done", int'(done), 1);
    check("B_ack_error", int'(ack_error), 0);

    // run C: entry 5 NACKed on every attempt
    nack_val = 8'h08;
    nack_limit = nacks_given + 100;
    pulse_start();
    wait_idle("C_idle", 20000);
    check("C_frames", frame_count, 30);
    check("C_ack_error", int'(ack_error), 1);
    check("C_done", int'(done), 0);
    check("C_i2s", int'(i2s_enable), 0);
    check("C_cur_index", int'(cur_index), 5);
    check("C_bus_released", int'({scl, sda_oe}), 2);
    nack_limit = nacks_given;

    for (int i = 0; i < 30; i++) begin
      check($sformatf("f%0d_b0", i), int'(log_b0[i]), 8'h34);
      check($sformatf("f%0d_b1", i), int'(log_b1[i]), int'(exp_b1[vecs[i].entry]));
      check($sformatf("f%0d_len", i), log_n[i], vecs[i].nacked ? 2 : 3);
      if (!vecs[i].nacked)
        check($sformatf("f%0d_b2", i), int'(log_b2[i]), int'(exp_b2[vecs[i].entry]));
    end

    // run D: asynchronous reset in the middle of entry 2, then restart
    base = frame_count;
    pulse_start();
    k = 0;
    while (!(frame_count == base + 2 && in_frame && byte_i == 1 && bit_i == 4
             && !scl && sda_oe) && k < 8000) begin
      @(negedge clk); k++;
    end
    check("D_reached_bit4", int'(k < 8000), 1);
    #2 reset = 1'b0; mon_clear = 1'b1;
    #1 check("D_async_reset", outs(), 10'h200);
    #1 reset = 1'b1;
    @(negedge clk) #2 mon_clear = 1'b0;
    base = frame_count;
    pulse_start();
    check("D_restart_busy", int'(busy), 1);
    wait_frames("D_first_frame", base + 1, 3000);
    check("D_restart_entry0", int'(log_b1[base]), 8'h1E);
    check("D_restart_len", log_n[base], 3);
    #2 reset = 1'b0; mon_clear = 1'b1;
    #1 check("D_abort_reset", outs(), 10'h200);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    check("proto_edges", bad_proto, 0);
    check("scl_high_len", bad_high, 0);
    check("scl_low_len", bad_low, 0);
    check("scl_pulses_seen", int'(good_high > 500), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
